// File: rtl/video_stream_packer_if.sv
// video_stream_packer_if: output pixel stream with valid/ready handshake and sof/eol framing tags
interface video_stream_packer_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  modport master (output pix_data, pix_valid, pix_sof, pix_eol, input pix_ready);
  modport slave (input pix_data, pix_valid, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/video_stream_packer.sv
// video_stream_packer: captures active video pixels into a FWFT FIFO with sof/eol tags and measures frame geometry
module video_stream_packer #(
  parameter int g_fifo_depth = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  input  logic                  valid,
  input  logic                  ovf_clr,
  video_stream_packer_if.master pix,
  output logic [11:0]           line_width,
  output logic [11:0]           frame_lines,
  output logic                  geom_valid,
  output logic                  overflow
);
  localparam int AW = $clog2(g_fifo_depth);
  localparam logic [AW:0] FULL = (AW+1)'(g_fifo_depth);
  typedef enum logic [1:0] {SEARCH, VBLANK, FRAME} state_t;
  state_t state_q, state_d;
  logic vs_q, vs_d, de_q, de_d;
  logic hold_v_q, hold_v_d, hold_sof_q, hold_sof_d, first_q, first_d;
  logic [23:0] hold_px_q, hold_px_d;
  logic [11:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d;
  logic [11:0] line_width_q, line_width_d, frame_lines_q, frame_lines_d;
  logic geom_valid_q, geom_valid_d, overflow_q, overflow_d;
  logic [25:0] mem_q [g_fifo_depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [25:0] head;
  logic rise, fall, de_fall, push, push_ok, pop, ovf_ev, capture, enter_frame, end_frame, not_empty;
  logic unused_hsync;
  assign unused_hsync = hsync;
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction
  // edges are taken between consecutive source cycles only, so idle cycles never create or hide an edge
  assign rise        = valid & vsync & ~vs_q;
  assign fall        = valid & ~vsync & vs_q;
  assign de_fall     = valid & ~de & de_q;
  assign not_empty   = cnt_q != '0;
  assign pop         = not_empty & pix.pix_ready;
  assign push        = valid & hold_v_q;
  assign push_ok     = push & ((cnt_q != FULL) | pop);
  assign ovf_ev      = push & ~push_ok;
  assign enter_frame = fall & (state_q == VBLANK);
  assign end_frame   = rise & (state_q == FRAME) & ~ovf_ev;
  assign capture     = valid & de & (state_q == FRAME) & ~rise & ~ovf_ev;
  assign head            = mem_q[rd_q];
  assign pix.pix_valid   = not_empty;
  assign pix.pix_data    = not_empty ? head[25:2] : '0;
  assign pix.pix_sof     = not_empty & head[1];
  assign pix.pix_eol     = not_empty & head[0];
  assign line_width      = line_width_q;
  assign frame_lines     = frame_lines_q;
  assign geom_valid      = geom_valid_q;
  assign overflow        = overflow_q;
  // next-state: frame tracking, one-pixel hold, line/pixel counters, geometry and FIFO pointers
  always_comb begin
    state_d       = ovf_ev ? SEARCH : rise ? VBLANK : enter_frame ? FRAME : state_q;
    vs_d          = valid ? vsync : vs_q;
    de_d          = valid ? de : de_q;
    hold_v_d      = capture | (hold_v_q & ~push);
    hold_px_d     = capture ? {r, g, b} : hold_px_q;
    hold_sof_d    = capture ? first_q : hold_sof_q;
    first_d       = enter_frame | (first_q & ~capture);
    pcnt_d        = enter_frame ? '0 : capture ? (de_q ? sat_inc(pcnt_q) : 12'd1) : pcnt_q;
    lcnt_d        = enter_frame ? '0 : (de_fall && state_q == FRAME) ? sat_inc(lcnt_q) : lcnt_q;
    line_width_d  = end_frame ? pcnt_q : line_width_q;
    frame_lines_d = end_frame ? lcnt_d : frame_lines_q;
    geom_valid_d  = geom_valid_q | end_frame;
    overflow_d    = ovf_ev | (overflow_q & ~ovf_clr);
    wr_d          = wr_q + AW'(push_ok);
    rd_d          = rd_q + AW'(pop);
    cnt_d         = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end
  // state registers; vs_q resets high so a vsync already high at reset is not taken as a fresh pulse
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= SEARCH;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      hold_v_q      <= 1'b0;
      hold_px_q     <= '0;
      hold_sof_q    <= 1'b0;
      first_q       <= 1'b0;
      pcnt_q        <= '0;
      lcnt_q        <= '0;
      line_width_q  <= '0;
      frame_lines_q <= '0;
      geom_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      hold_v_q      <= hold_v_d;
      hold_px_q     <= hold_px_d;
      hold_sof_q    <= hold_sof_d;
      first_q       <= first_d;
      pcnt_q        <= pcnt_d;
      lcnt_q        <= lcnt_d;
      line_width_q  <= line_width_d;
      frame_lines_q <= frame_lines_d;
      geom_valid_q  <= geom_valid_d;
      overflow_q    <= overflow_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
    end
  end
  // FIFO storage holds {pixel, sof, eol}; emptiness is tracked by the count so contents need no reset
  always_ff @(posedge pclk) begin
    if (push_ok) mem_q[wr_q] <= {hold_px_q, hold_sof_q, ~de | rise};
  end
endmodule
